// File: rtl/controle_es.sv
// controle_es -- I/O handshake responder between the control unit and the
// board's pushbutton, switches and display.
//
// When the control unit stalls on an `in` or `out` instruction, this block
// waits for a debounced button press. It then returns a one-cycle `sinal`
// pulse so that the control unit can complete the instruction.
//
// Optional build macro: ES_AUTOCONFIRMA_EN
//   When defined, an AGUARDA cycle counter confirms automatically after
//   AUTO_CICLOS cycles. A real debounced press can still confirm first.
//
// Ports:
//   clock           system clock (rising edge)
//   reset           asynchronous reset, active low
//   in / out        input / output request from the control unit
//   stop            stall or halt from the control unit
//   botao           raw pushbutton, 1 = pressed (asynchronous)
//   chaves          raw switches, captured into dado_in on an `in` confirm
//   dado_out        register value, latched for the display on an `out` request
//   sinal           registered one-cycle confirmation pulse
//   dado_in         captured switch value, zero-extended to 32 bits
//   display_val     latched display value
//   display_valido  1 once any `out` has been latched
//   esperando       1 while waiting for the user
//   parado          registered halt indicator (stop=1, in=out=0)
module controle_es #(
    parameter int unsigned LARGURA_CHAVES  = 16,
    parameter int unsigned DEBOUNCE_CICLOS = 500000,
    parameter int unsigned AUTO_CICLOS     = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in,
    input  logic                      out,
    input  logic                      stop,
    input  logic                      botao,
    input  logic [LARGURA_CHAVES-1:0] chaves,
    input  logic [31:0]               dado_out,
    output logic                      sinal,
    output logic [31:0]               dado_in,
    output logic [31:0]               display_val,
    output logic                      display_valido,
    output logic                      esperando,
    output logic                      parado
);

    if (DEBOUNCE_CICLOS == 0 || AUTO_CICLOS == 0) begin : g_parametro_invalido
        $error("controle_es: DEBOUNCE_CICLOS and AUTO_CICLOS must be at least 1");
    end

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [DB_W-1:0] DB_FIM = DB_W'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [1:0] {
        OCIOSO,
        AGUARDA,
        CONFIRMA,
        LIBERA
    } estado_t;

    estado_t         estado;
    logic            eh_in;          // pending request is an `in`
    logic [1:0]      sinc;           // two-flop button synchronizer
    logic [DB_W-1:0] db_cnt;
    logic            botao_estavel;
    logic            estavel_q;
    logic            press;
    logic            confirma;

    // Debouncer: the stable level flips only after the synchronized button
    // has disagreed with it for DEBOUNCE_CICLOS consecutive cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc          <= '0;
            db_cnt        <= '0;
            botao_estavel <= 1'b0;
            estavel_q     <= 1'b0;
        end else begin
            sinc      <= {sinc[0], botao};
            estavel_q <= botao_estavel;
            if (sinc[1] == botao_estavel) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_FIM) begin
                botao_estavel <= ~botao_estavel;
                db_cnt        <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    always_comb begin
        press = botao_estavel & ~estavel_q;
    end

`ifdef ES_AUTOCONFIRMA_EN
    localparam int unsigned AUTO_W = $clog2(AUTO_CICLOS + 1);
    localparam logic [AUTO_W-1:0] AUTO_FIM = AUTO_W'(AUTO_CICLOS);

    logic [AUTO_W-1:0] auto_cnt;

    // Counts cycles spent in AGUARDA; restarts from 0 on every entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            auto_cnt <= '0;
        end else if (estado != AGUARDA) begin
            auto_cnt <= '0;
        end else if (auto_cnt != AUTO_FIM) begin
            auto_cnt <= auto_cnt + AUTO_W'(1);
        end
    end

    always_comb begin
        confirma = press | ((estado == AGUARDA) && (auto_cnt == AUTO_FIM));
    end
`else
    always_comb begin
        confirma = press;
    end
`endif

    // Handshake FSM. All outputs are registered and updated together with
    // the state, so `sinal` is high exactly while the FSM is in CONFIRMA.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado         <= OCIOSO;
            eh_in          <= 1'b0;
            sinal          <= 1'b0;
            esperando      <= 1'b0;
            parado         <= 1'b0;
            dado_in        <= '0;
            display_val    <= '0;
            display_valido <= 1'b0;
        end else begin
            parado <= stop & ~in & ~out;
            sinal  <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (in) begin
                        estado    <= AGUARDA;
                        eh_in     <= 1'b1;
                        esperando <= 1'b1;
                    end else if (out) begin
                        estado         <= AGUARDA;
                        eh_in          <= 1'b0;
                        esperando      <= 1'b1;
                        display_val    <= dado_out;
                        display_valido <= 1'b1;
                    end
                end
                AGUARDA: begin
                    // A withdrawn request wins over a coincident press.
                    if (!in && !out) begin
                        estado    <= OCIOSO;
                        esperando <= 1'b0;
                    end else if (confirma) begin
                        estado    <= CONFIRMA;
                        esperando <= 1'b0;
                        sinal     <= 1'b1;
                        if (eh_in) begin
                            dado_in <= 32'(chaves);
                        end
                    end
                end
                CONFIRMA: begin
                    estado <= LIBERA;
                end
                LIBERA: begin
                    // Held button must be released before the next request.
                    if (!botao_estavel) begin
                        estado <= OCIOSO;
                    end
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule
